// File: rtl/lbm_pkg.sv
// Shared types and constants for the lattice-Boltzmann step controller.
// Velocity tables follow D2Q9 ordering; D2Q5 uses the first five entries.
package lbm_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_COL_MOM1,
        S_COL_MOM2,
        S_COL_DIV,
        S_COL_WAIT,
        S_COL_U_LD,
        S_COL_U_WB,
        S_COL_EQ_LD,
        S_COL_EQ_WB,
        S_COL_OUT,
        S_STREAM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic signed [1:0] CX [9] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, -2'sd1, 2'sd1};
    localparam logic signed [1:0] CY [9] = '{2'sd0, 2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd1, 2'sd1, -2'sd1, -2'sd1};

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } node_coord_t;

endpackage

// File: rtl/lbm_neighbor_addr.sv
// Streaming destination address: neighbour of (x, y) along direction dir,
// wrapped periodically at the lattice edges with compare/select only.
module lbm_neighbor_addr
    import lbm_pkg::*;
#(
    parameter int GRID_X        = 16,
    parameter int GRID_Y        = 16,
    parameter int Q             = 9,
    parameter int ADDRESS_WIDTH = $clog2(GRID_X * GRID_Y),
    parameter int DIR_W         = $clog2(Q)
) (
    input  logic [COORD_W-1:0]       x,
    input  logic [COORD_W-1:0]       y,
    input  logic [DIR_W-1:0]         dir,
    output logic [ADDRESS_WIDTH-1:0] dst_addr
);

    logic signed [1:0]  cx;
    logic signed [1:0]  cy;
    logic [COORD_W-1:0] xn;
    logic [COORD_W-1:0] yn;

    always_comb begin
        cx = 2'sd0;
        cy = 2'sd0;
        for (int i = 0; i < Q; i++) begin
            if (int'(dir) == i) begin
                cx = CX[i];
                cy = CY[i];
            end
        end

        xn = x;
        if (cx == 2'sd1)
            xn = (x == COORD_W'(GRID_X - 1)) ? '0 : x + COORD_W'(1);
        else if (cx == -2'sd1)
            xn = (x == '0) ? COORD_W'(GRID_X - 1) : x - COORD_W'(1);

        yn = y;
        if (cy == 2'sd1)
            yn = (y == COORD_W'(GRID_Y - 1)) ? '0 : y + COORD_W'(1);
        else if (cy == -2'sd1)
            yn = (y == '0) ? COORD_W'(GRID_Y - 1) : y - COORD_W'(1);

        dst_addr = ADDRESS_WIDTH'(yn * COORD_W'(GRID_X) + xn);
    end

endmodule

// File: rtl/lbm_step_controller.sv
// Time-step sequencer for the LBM datapath: init, per-node collide with a
// divider handshake, per-direction streaming, repeated num_steps times.
module lbm_step_controller
    import lbm_pkg::*;
#(
    parameter int GRID_X        = 16,
    parameter int GRID_Y        = 16,
    parameter int Q             = 9,
    parameter int ADDRESS_WIDTH = $clog2(GRID_X * GRID_Y),
    parameter int STEP_WIDTH    = 16,
    parameter int DIV_TIMEOUT   = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [STEP_WIDTH-1:0]    num_steps,
    input  logic                     div_valid,
    output logic                     div_start,
    output logic [ADDRESS_WIDTH-1:0] node_addr,
    output logic [ADDRESS_WIDTH-1:0] stream_dst_addr,
    output logic [$clog2(Q)-1:0]     dir_sel,
    output logic                     select_init,
    output logic                     WE_p_mem,
    output logic                     WE_ux_mem,
    output logic                     WE_uy_mem,
    output logic                     WE_fin_mem,
    output logic                     WE_feq_mem,
    output logic                     WE_fout_mem,
    output logic                     LD_EN_P,
    output logic                     LD_EN_PUX,
    output logic                     LD_EN_PUY,
    output logic                     LD_EN_U,
    output logic [Q-1:0]             LD_EN_FEQ,
    output logic                     busy,
    output logic                     done,
    output logic                     div_timeout,
    output logic [STEP_WIDTH-1:0]    step_count
);

    localparam int DIR_W  = $clog2(Q);
    localparam int WAIT_W = $clog2(DIV_TIMEOUT + 1);

    if (!(Q == 9 || Q == 5)) begin : g_bad_q
        $error("lbm_step_controller: Q must be 9 or 5");
    end

    state_t                state;
    node_coord_t           coord;
    node_coord_t           coord_nxt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [STEP_WIDTH-1:0] steps_tgt;
    logic [STEP_WIDTH-1:0] step_inc;
    logic                  last_node;

    assign last_node = (node_addr == ADDRESS_WIDTH'(GRID_X * GRID_Y - 1));
    assign step_inc  = step_count + STEP_WIDTH'(1);

    // x/y are tracked alongside the flat address so the neighbour logic never divides.
    always_comb begin
        coord_nxt = coord;
        if (coord.x == COORD_W'(GRID_X - 1)) begin
            coord_nxt.x = '0;
            coord_nxt.y = coord.y + COORD_W'(1);
        end else begin
            coord_nxt.x = coord.x + COORD_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= S_IDLE;
            coord      <= '0;
            node_addr  <= '0;
            dir_sel    <= '0;
            wait_cnt   <= '0;
            step_count <= '0;
            steps_tgt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        steps_tgt  <= num_steps;
                        step_count <= '0;
                        coord      <= '0;
                        node_addr  <= '0;
                        dir_sel    <= '0;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (last_node) begin
                        coord     <= '0;
                        node_addr <= '0;
                        state     <= (steps_tgt == '0) ? S_DONE : S_COL_MOM1;
                    end else begin
                        coord     <= coord_nxt;
                        node_addr <= node_addr + ADDRESS_WIDTH'(1);
                    end
                end
                S_COL_MOM1: state <= S_COL_MOM2;
                S_COL_MOM2: state <= S_COL_DIV;
                S_COL_DIV: begin
                    wait_cnt <= '0;
                    state    <= S_COL_WAIT;
                end
                S_COL_WAIT: begin
                    if (div_valid)
                        state <= S_COL_U_LD;
                    else if (wait_cnt == WAIT_W'(DIV_TIMEOUT - 1))
                        state <= S_ERROR;
                    else
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                S_COL_U_LD:  state <= S_COL_U_WB;
                S_COL_U_WB:  state <= S_COL_EQ_LD;
                S_COL_EQ_LD: state <= S_COL_EQ_WB;
                S_COL_EQ_WB: state <= S_COL_OUT;
                S_COL_OUT: begin
                    if (last_node) begin
                        coord     <= '0;
                        node_addr <= '0;
                        dir_sel   <= '0;
                        state     <= S_STREAM;
                    end else begin
                        coord     <= coord_nxt;
                        node_addr <= node_addr + ADDRESS_WIDTH'(1);
                        state     <= S_COL_MOM1;
                    end
                end
                S_STREAM: begin
                    if (dir_sel == DIR_W'(Q - 1)) begin
                        dir_sel <= '0;
                        if (last_node) begin
                            coord      <= '0;
                            node_addr  <= '0;
                            step_count <= step_inc;
                            state      <= (step_inc == steps_tgt) ? S_DONE : S_COL_MOM1;
                        end else begin
                            coord     <= coord_nxt;
                            node_addr <= node_addr + ADDRESS_WIDTH'(1);
                        end
                    end else begin
                        dir_sel <= dir_sel + DIR_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        div_start   = 1'b0;
        select_init = 1'b0;
        WE_p_mem    = 1'b0;
        WE_ux_mem   = 1'b0;
        WE_uy_mem   = 1'b0;
        WE_fin_mem  = 1'b0;
        WE_feq_mem  = 1'b0;
        WE_fout_mem = 1'b0;
        LD_EN_P     = 1'b0;
        LD_EN_PUX   = 1'b0;
        LD_EN_PUY   = 1'b0;
        LD_EN_U     = 1'b0;
        LD_EN_FEQ   = '0;
        done        = 1'b0;
        div_timeout = 1'b0;
        busy        = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
        case (state)
            S_INIT: begin
                select_init = 1'b1;
                WE_p_mem    = 1'b1;
                WE_ux_mem   = 1'b1;
                WE_uy_mem   = 1'b1;
                WE_fin_mem  = 1'b1;
            end
            S_COL_MOM1: begin
                LD_EN_P   = 1'b1;
                LD_EN_PUX = 1'b1;
                LD_EN_PUY = 1'b1;
            end
            S_COL_MOM2:  WE_p_mem  = 1'b1;
            S_COL_DIV:   div_start = 1'b1;
            S_COL_U_LD:  LD_EN_U   = 1'b1;
            S_COL_U_WB: begin
                WE_ux_mem = 1'b1;
                WE_uy_mem = 1'b1;
            end
            S_COL_EQ_LD: LD_EN_FEQ   = '1;
            S_COL_EQ_WB: WE_feq_mem  = 1'b1;
            S_COL_OUT:   WE_fout_mem = 1'b1;
            S_STREAM:    WE_fin_mem  = 1'b1;
            S_DONE:      done        = 1'b1;
            S_ERROR:     div_timeout = 1'b1;
            default: ;
        endcase
    end

    lbm_neighbor_addr #(
        .GRID_X       (GRID_X),
        .GRID_Y       (GRID_Y),
        .Q            (Q),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DIR_W        (DIR_W)
    ) u_neighbor (
        .x       (coord.x),
        .y       (coord.y),
        .dir     (dir_sel),
        .dst_addr(stream_dst_addr)
    );

endmodule

// File: tb/tb_lbm_step_controller.sv
// Directed bench for lbm_step_controller on a 4x4 lattice (Q=9 and Q=5 instances)
// plus a table of wrap-address vectors for the neighbour block.
module tb_lbm_step_controller;
    import lbm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [15:0] num_steps = '0;
    logic        dv = 1'b0;
    logic        start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    // Q=9 instance outputs
    logic a_div_start, a_sel_init, a_we_p, a_we_ux, a_we_uy, a_we_fin, a_we_feq, a_we_fout;
    logic a_ld_p, a_ld_pux, a_ld_puy, a_ld_u, a_busy, a_done, a_to;
    logic [3:0] a_node, a_dst, a_dir;
    logic [8:0] a_ld_feq;
    logic [15:0] a_step;
    // Q=5 instance outputs
    logic b_div_start, b_sel_init, b_we_p, b_we_ux, b_we_uy, b_we_fin, b_we_feq, b_we_fout;
    logic b_ld_p, b_ld_pux, b_ld_puy, b_ld_u, b_busy, b_done, b_to;
    logic [3:0] b_node, b_dst;
    logic [2:0] b_dir;
    logic [4:0] b_ld_feq;
    logic [15:0] b_step;

    lbm_step_controller #(.GRID_X(4), .GRID_Y(4), .Q(9), .STEP_WIDTH(16), .DIV_TIMEOUT(8)) dut_a (
        .Clk(clk), .Reset(rst_n), .start(start_a), .num_steps(num_steps), .div_valid(dv),
        .div_start(a_div_start), .node_addr(a_node), .stream_dst_addr(a_dst), .dir_sel(a_dir),
        .select_init(a_sel_init), .WE_p_mem(a_we_p), .WE_ux_mem(a_we_ux), .WE_uy_mem(a_we_uy),
        .WE_fin_mem(a_we_fin), .WE_feq_mem(a_we_feq), .WE_fout_mem(a_we_fout),
        .LD_EN_P(a_ld_p), .LD_EN_PUX(a_ld_pux), .LD_EN_PUY(a_ld_puy), .LD_EN_U(a_ld_u),
        .LD_EN_FEQ(a_ld_feq), .busy(a_busy), .done(a_done), .div_timeout(a_to), .step_count(a_step));

    lbm_step_controller #(.GRID_X(4), .GRID_Y(4), .Q(5), .STEP_WIDTH(16), .DIV_TIMEOUT(8)) dut_b (
        .Clk(clk), .Reset(rst_n), .start(start_b), .num_steps(num_steps), .div_valid(dv),
        .div_start(b_div_start), .node_addr(b_node), .stream_dst_addr(b_dst), .dir_sel(b_dir),
        .select_init(b_sel_init), .WE_p_mem(b_we_p), .WE_ux_mem(b_we_ux), .WE_uy_mem(b_we_uy),
        .WE_fin_mem(b_we_fin), .WE_feq_mem(b_we_feq), .WE_fout_mem(b_we_fout),
        .LD_EN_P(b_ld_p), .LD_EN_PUX(b_ld_pux), .LD_EN_PUY(b_ld_puy), .LD_EN_U(b_ld_u),
        .LD_EN_FEQ(b_ld_feq), .busy(b_busy), .done(b_done), .div_timeout(b_to), .step_count(b_step));

    logic [COORD_W-1:0] nx = '0, ny = '0;
    logic [3:0] nd = '0, nb_dst;
    lbm_neighbor_addr #(.GRID_X(4), .GRID_Y(4), .Q(9), .ADDRESS_WIDTH(4), .DIR_W(4)) u_nb (
        .x(nx), .y(ny), .dir(nd), .dst_addr(nb_dst));

    // Monitored view of whichever instance is selected
    logic m_div_start, m_sel_init, m_we_fin, m_done, m_to, m_busy, m_feq_all, m_we_fout;
    logic [3:0] m_node, m_dst, m_dir;
    logic [15:0] m_step;
    assign m_div_start = sel ? b_div_start : a_div_start;
    assign m_sel_init  = sel ? b_sel_init  : a_sel_init;
    assign m_we_fin    = sel ? b_we_fin    : a_we_fin;
    assign m_we_fout   = sel ? b_we_fout   : a_we_fout;
    assign m_done      = sel ? b_done      : a_done;
    assign m_to        = sel ? b_to        : a_to;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_feq_all   = sel ? (&b_ld_feq) : (&a_ld_feq);
    assign m_node      = sel ? b_node      : a_node;
    assign m_dst       = sel ? b_dst       : a_dst;
    assign m_dir       = sel ? {1'b0, b_dir} : a_dir;
    assign m_step      = sel ? b_step      : a_step;

    logic [53:0] a_all;
    assign a_all = {a_div_start, a_node, a_dst, a_dir, a_sel_init, a_we_p, a_we_ux, a_we_uy,
                    a_we_fin, a_we_feq, a_we_fout, a_ld_p, a_ld_pux, a_ld_puy, a_ld_u,
                    a_ld_feq, a_busy, a_done, a_to, a_step};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference neighbour on the 4x4 torus using modular arithmetic
    function automatic int exp_dst(input int node, input int dir);
        int cxt[9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
        int cyt[9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
        int x, y;
        x = (node % 4 + cxt[dir] + 4) % 4;
        y = (node / 4 + cyt[dir] + 4) % 4;
        return y * 4 + x;
    endfunction

    // Divider model: div_valid one cycle, two cycles after div_start
    bit resp_en = 1'b1;
    int pend = 0;
    initial begin
        forever begin
            @(negedge clk);
            dv = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) dv = 1'b1;
            end
            if (m_div_start && resp_en) pend = 2;
        end
    end

    int c_init, c_div, c_fin, c_done, c_feq, c_fout, first_div, last_div, max_dir, dst_err;
    bit got_to;

    task automatic kick(input bit s, input int n);
        @(negedge clk);
        sel = s;
        num_steps = 16'(n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts events each cycle until done or div_timeout appears
    task automatic watch(input string name, input int budget);
        bit stop;
        c_init = 0; c_div = 0; c_fin = 0; c_done = 0; c_feq = 0; c_fout = 0;
        first_div = 0; last_div = 0; max_dir = 0; dst_err = 0; got_to = 0; stop = 0;
        for (int i = 0; i < budget && !stop; i++) begin
            @(negedge clk);
            if (m_sel_init && m_we_fin) c_init++;
            if (m_feq_all) c_feq++;
            if (m_we_fout) c_fout++;
            if (m_div_start) begin
                if (c_div == 0) first_div = i;
                if (c_div == 15) last_div = i;
                c_div++;
            end
            if (m_we_fin && !m_sel_init) begin
                c_fin++;
                if (int'(m_dir) > max_dir) max_dir = int'(m_dir);
                if (int'(m_dir) > 8 || int'(m_dst) != exp_dst(int'(m_node), int'(m_dir))) dst_err++;
            end
            if (m_done) c_done++;
            if (m_to) got_to = 1;
            if (m_done || m_to) stop = 1;
        end
        if (!stop) chk({name, "_budget"}, 0, 1);
    endtask

    typedef struct {
        int x;
        int y;
        int dir;
        int exp;
    } nb_vec_t;
    nb_vec_t tbl[10];

    initial begin
        int k;
        tbl[0] = '{3, 0, 1, 0};
        tbl[1] = '{0, 0, 7, 15};
        tbl[2] = '{0, 3, 2, 0};
        tbl[3] = '{1, 1, 0, 5};
        tbl[4] = '{2, 1, 3, 5};
        tbl[5] = '{1, 0, 4, 13};
        tbl[6] = '{3, 3, 5, 0};
        tbl[7] = '{0, 2, 6, 15};
        tbl[8] = '{3, 0, 8, 12};
        tbl[9] = '{2, 2, 1, 11};
        foreach (tbl[i]) begin
            nx = COORD_W'(tbl[i].x);
            ny = COORD_W'(tbl[i].y);
            nd = 4'(tbl[i].dir);
            #1;
            chk($sformatf("nb_x%0d_y%0d_q%0d", tbl[i].x, tbl[i].y, tbl[i].dir), int'(nb_dst), tbl[i].exp);
        end

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs_nonzero", int'(|a_all), 0);
        chk("reset_busy", int'(a_busy), 0);
        chk("reset_step", int'(a_step), 0);
        rst_n = 1'b1;
        start = 1'b0;

        // One full step
        kick(0, 1);
        watch("step1", 2000);
        chk("step1_init", c_init, 16);
        chk("step1_divs", c_div, 16);
        chk("step1_node_period", last_div - first_div, 150);
        chk("step1_feq", c_feq, 16);
        chk("step1_fout", c_fout, 16);
        chk("step1_fin", c_fin, 144);
        chk("step1_maxdir", max_dir, 8);
        chk("step1_dst", dst_err, 0);
        chk("step1_done", c_done, 1);
        chk("step1_count", int'(a_step), 1);
        @(negedge clk);
        chk("step1_done_pulse", int'(a_done), 0);
        chk("step1_idle_busy", int'(a_busy), 0);
        chk("step1_hold_count", int'(a_step), 1);

        // Three steps
        kick(0, 3);
        watch("step3", 4000);
        chk("step3_divs", c_div, 48);
        chk("step3_fin", c_fin, 432);
        chk("step3_count", int'(a_step), 3);
        chk("step3_dst", dst_err, 0);

        // Zero steps, then start coinciding with DONE
        kick(0, 0);
        watch("step0", 200);
        chk("step0_init", c_init, 16);
        chk("step0_divs", c_div, 0);
        chk("step0_done", c_done, 1);
        chk("step0_count", int'(a_step), 0);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_done_busy", int'(a_busy), 0);
        chk("start_in_done_init", int'(a_sel_init), 0);
        start = 1'b0;

        // D2Q5 instance
        kick(1, 1);
        watch("q5", 2000);
        chk("q5_fin", c_fin, 80);
        chk("q5_maxdir", max_dir, 4);
        chk("q5_dst", dst_err, 0);
        chk("q5_done", c_done, 1);
        chk("q5_count", int'(b_step), 1);

        // Divider timeout with a start pulse during COL_WAIT
        resp_en = 1'b0;
        kick(0, 1);
        k = 0;
        while (!a_div_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_saw_div_start", int'(a_div_start), 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 2;
        while (!a_to && !a_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", k, 9);
        chk("to_flag", int'(a_to), 1);
        chk("to_busy", int'(a_busy), 0);
        chk("to_no_done", int'(a_done), 0);
        repeat (3) @(negedge clk);
        chk("to_sticky", int'(a_to), 1);
        resp_en = 1'b1;
        kick(0, 0);
        chk("to_cleared", int'(a_to), 0);
        chk("to_restart_busy", int'(a_busy), 1);
        watch("to_rerun", 200);
        chk("to_rerun_done", c_done, 1);

        // Reset in the middle of streaming
        kick(0, 1);
        k = 0;
        while (!(a_we_fin && !a_sel_init) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_saw_stream", int'(a_we_fin && !a_sel_init), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs_nonzero", int'(|a_all), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_reset_stays_idle", int'(a_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
